// File: rtl/alu_test.sv
// alu_test: single-cycle registered 16-bit ALU.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset; clears all outputs at once
//   A, B      16-bit operands (B[3:0] is the shift amount for shift ops)
//   alu_code  {class[4:3], op[2:0]} opcode
//   coe       carry-out enable, active-low (1 forces cout to 0)
//   C         registered result
//   vout      registered overflow / borrow flag
//   cout      registered carry-out flag
//
// Inputs are sampled on every rising edge and the result appears one cycle
// later. There is no handshake.
module alu_test (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [4:0]  alu_code,
  input  logic        coe,
  output logic [15:0] C,
  output logic        vout,
  output logic        cout
);

  typedef struct packed {
    logic [15:0] c;
    logic        v;
    logic        co;
  } alu_res_t;

  alu_res_t    res_d, res_q;

  // Every arithmetic op goes through one 17-bit adder. Subtract and
  // decrement feed the inverted operand with carry-in 1, so sum[16] is the
  // raw carry (1 = no borrow).
  logic [15:0] opnd;
  logic        cin;
  logic [16:0] sum;
  logic        sovf;

  always_comb begin
    opnd = B;
    cin  = 1'b0;
    case (alu_code[2:0])
      3'd2, 3'd3: begin opnd = ~B;       cin = 1'b1; end
      3'd4:       begin opnd = 16'h0001; cin = 1'b0; end
      3'd5:       begin opnd = 16'hFFFE; cin = 1'b1; end
      default:    begin opnd = B;        cin = 1'b0; end
    endcase
  end

  assign sum  = {1'b0, A} + {1'b0, opnd} + {16'd0, cin};
  // Two's-complement overflow: effective operand signs agree but the
  // result sign does not.
  assign sovf = (A[15] == opnd[15]) && (sum[15] != A[15]);

  logic               [3:0]  sh;
  logic signed        [15:0] a_s;
  logic               [15:0] sra_res;
  logic                      lt, eq;

  assign sh      = B[3:0];
  assign a_s     = A;
  assign sra_res = a_s >>> sh;
  assign lt      = $signed(A) < $signed(B);
  assign eq      = (A == B);

  always_comb begin
    res_d = '0;
    case (alu_code)
      // arithmetic
      5'b00000, 5'b00010, 5'b00100, 5'b00101: begin
        res_d.c  = sum[15:0];
        res_d.v  = sovf;
        res_d.co = sum[16] & ~coe;
      end
      5'b00001: begin
        res_d.c  = sum[15:0];
        res_d.v  = sum[16];
        res_d.co = sum[16] & ~coe;
      end
      5'b00011: begin
        res_d.c  = sum[15:0];
        res_d.v  = ~sum[16];
        res_d.co = sum[16] & ~coe;
      end
      // logic
      5'b01000: res_d.c = A & B;
      5'b01001: res_d.c = A | B;
      5'b01010: res_d.c = A ^ B;
      5'b01100: res_d.c = ~A;
      // shifts; sla is a plain zero-fill left shift like sll
      5'b10000, 5'b10010: res_d.c = A << sh;
      5'b10001:           res_d.c = A >> sh;
      5'b10011:           res_d.c = sra_res;
      // signed compares
      5'b11000: res_d.c = {15'd0, lt | eq};
      5'b11001: res_d.c = {15'd0, lt};
      5'b11010: res_d.c = {15'd0, ~lt};
      5'b11011: res_d.c = {15'd0, ~(lt | eq)};
      5'b11100: res_d.c = {15'd0, eq};
      5'b11101: res_d.c = {15'd0, ~eq};
      default:  res_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= '0;
    else        res_q <= res_d;
  end

  assign C    = res_q.c;
  assign vout = res_q.v;
  assign cout = res_q.co;

endmodule

// File: tb/tb_alu_test.sv
// Directed testbench for alu_test: hand-computed vectors, one result per
// clock, plus asynchronous reset behaviour.
module tb_alu_test;

  logic        clk;
  logic        rst_n;
  logic [15:0] A, B;
  logic [4:0]  alu_code;
  logic        coe;
  logic [15:0] C;
  logic        vout, cout;

  int n_chk  = 0;
  int n_fail = 0;

  alu_test dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .alu_code (alu_code),
    .coe      (coe),
    .C        (C),
    .vout     (vout),
    .cout     (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] ec, input logic ev, input logic eco);
    check({tag, ".C"},    C,            ec);
    check({tag, ".vout"}, {15'd0, vout}, {15'd0, ev});
    check({tag, ".cout"}, {15'd0, cout}, {15'd0, eco});
  endtask

  // Drive on the falling edge, sample just after the next rising edge.
  task automatic op(input string tag, input logic [4:0] code, input logic [15:0] a,
                    input logic [15:0] b, input logic ce,
                    input logic [15:0] ec, input logic ev, input logic eco);
    @(negedge clk);
    alu_code = code; A = a; B = b; coe = ce;
    @(posedge clk);
    #1;
    chk_out(tag, ec, ev, eco);
  endtask

  initial begin
    rst_n = 1'b1; A = 16'h0; B = 16'h0; alu_code = 5'b0; coe = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_out("reset", 16'h0000, 1'b0, 1'b0);

    // Inputs that would give a nonzero result must not leak while in reset.
    alu_code = 5'b00000; A = 16'hA00A; B = 16'h1004;
    repeat (2) @(posedge clk);
    #1 chk_out("reset_hold", 16'h0000, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    op("add1",   5'b00000, 16'hA00A, 16'h1004, 1'b0, 16'hB00E, 1'b0, 1'b0);
    op("add2",   5'b00000, 16'h8012, 16'h8002, 1'b0, 16'h0014, 1'b1, 1'b1);
    op("add2c",  5'b00000, 16'h8012, 16'h8002, 1'b1, 16'h0014, 1'b1, 1'b0);
    op("sub",    5'b00010, 16'h8012, 16'h8002, 1'b0, 16'h0010, 1'b0, 1'b1);
    op("subc",   5'b00010, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0);
    op("subu",   5'b00011, 16'h1004, 16'hA00A, 1'b0, 16'h6FFA, 1'b1, 1'b0);
    op("addu",   5'b00001, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
    op("inc_ov", 5'b00100, 16'h7FFF, 16'h1234, 1'b0, 16'h8000, 1'b1, 1'b0);
    op("inc_wr", 5'b00100, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    op("dec_ov", 5'b00101, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    op("dec_0",  5'b00101, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0);

    op("sll",    5'b10000, 16'hF14A, 16'hF002, 1'b0, 16'hC528, 1'b0, 1'b0);
    op("srl",    5'b10001, 16'hF14A, 16'hF002, 1'b0, 16'h3C52, 1'b0, 1'b0);
    op("sra",    5'b10011, 16'hF14A, 16'hF002, 1'b0, 16'hFC52, 1'b0, 1'b0);
    op("sla",    5'b10010, 16'hF14A, 16'hF002, 1'b0, 16'hC528, 1'b0, 1'b0);
    op("sll_n0", 5'b10000, 16'hF14A, 16'h0010, 1'b0, 16'hF14A, 1'b0, 1'b0);
    op("sra_15", 5'b10011, 16'h8000, 16'h000F, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    op("srl_15", 5'b10001, 16'h8000, 16'h000F, 1'b0, 16'h0001, 1'b0, 1'b0);

    op("sgt",    5'b11011, 16'hF14A, 16'hF002, 1'b0, 16'h0001, 1'b0, 1'b0);
    op("sge",    5'b11010, 16'hF14A, 16'hF002, 1'b0, 16'h0001, 1'b0, 1'b0);
    op("sne",    5'b11101, 16'hF14A, 16'hF002, 1'b0, 16'h0001, 1'b0, 1'b0);
    op("slt",    5'b11001, 16'hF14A, 16'hF002, 1'b0, 16'h0000, 1'b0, 1'b0);
    op("sle",    5'b11000, 16'hF14A, 16'hF002, 1'b0, 16'h0000, 1'b0, 1'b0);
    op("seq",    5'b11100, 16'hF14A, 16'hF002, 1'b0, 16'h0000, 1'b0, 1'b0);
    op("sle_eq", 5'b11000, 16'h0001, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0);
    op("slt_eq", 5'b11001, 16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0);
    op("seq_eq", 5'b11100, 16'h0001, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0);
    op("slt_sg", 5'b11001, 16'h8000, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0);

    op("not",    5'b01100, 16'hF14A, 16'hF002, 1'b0, 16'h0EB5, 1'b0, 1'b0);
    op("and",    5'b01000, 16'hF14A, 16'hF002, 1'b0, 16'hF002, 1'b0, 1'b0);
    op("xor",    5'b01010, 16'hF14A, 16'hF002, 1'b0, 16'h0148, 1'b0, 1'b0);
    op("or",     5'b01001, 16'hA00A, 16'h1004, 1'b0, 16'hB00E, 1'b0, 1'b0);

    op("undef0", 5'b00110, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0);
    op("undef1", 5'b01011, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0);
    op("undef2", 5'b10101, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0);
    op("undef3", 5'b11111, 16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Mid-stream reset: previous result is nonzero, the in-flight add
    // FFFF+0001 must be discarded, and outputs clear without a clock edge.
    op("pre_rst", 5'b00000, 16'hA00A, 16'h1004, 1'b0, 16'hB00E, 1'b0, 1'b0);
    @(negedge clk);
    alu_code = 5'b00000; A = 16'hFFFF; B = 16'h0001; coe = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk_out("rst_edge", 16'h0000, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk_out("post_rst", 16'h0000, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_test.md
ALU_TEST -- requirements
Module: alu_test

Interface
REQ-001 Ports SHALL be as follows; one clock; reset asynchronous, active-low.
REQ-002 clk  input  1  rising-edge clock for all registers.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 A  input  16  operand A, two's-complement or unsigned depending on opcode.
REQ-005 B  input  16  operand B; shifts use B[3:0] only.
REQ-006 alu_code  input  5  opcode; {class[4:3], op[2:0]}.
REQ-007 coe  input  1  carry-out enable, active-low; coe=1 forces cout=0.
REQ-008 C  output  16  registered result.
REQ-009 vout  output  1  registered overflow flag.
REQ-010 cout  output  1  registered carry-out flag.

Function
REQ-011 A, B, alu_code and coe SHALL be sampled on each rising clk edge; C, vout and cout SHALL update on that edge (latency 1 cycle, one result per cycle, no handshake).
REQ-012 Arithmetic class 00: add 00000 = A+B signed; addu 00001 = A+B unsigned; sub 00010 = A-B signed; subu 00011 = A-B unsigned; inc 00100 = A+1 signed; dec 00101 = A-1 signed; C = low 16 bits, modulo 2^16 wrap.
REQ-013 Subtraction and dec SHALL be computed as A + ~operand + 1; raw carry = bit 16 of that 17-bit sum (1 = no borrow).
REQ-014 Signed ops (add, sub, inc, dec): vout = 1 iff operands' effective signs match and result sign differs (two's-complement overflow).
REQ-015 Unsigned ops: addu vout = raw carry; subu vout = borrow = NOT raw carry.
REQ-016 Arithmetic ops: cout = raw carry when coe=0, else 0.
REQ-017 Logic class 01: and 01000 = A&B; or 01001 = A|B; xor 01010 = A^B; not 01100 = ~A; vout=0, cout=0.
REQ-018 Shift class 10, n = B[3:0] (0..15): sll 10000 = A<<n zero-fill; srl 10001 = A>>n zero-fill; sla 10010 = A<<n zero-fill (same result as sll); sra 10011 = A>>n sign-fill with A[15]; n=0 passes A; vout=0, cout=0.
REQ-019 Set class 11, signed compare: sle 11000 (A<=B), slt 11001 (A<B), sge 11010 (A>=B), sgt 11011 (A>B), seq 11100 (A==B), sne 11101 (A!=B); C=16'h0001 if true else 16'h0000; vout=0, cout=0.
REQ-020 Undefined opcodes (00110, 00111, 01011, 01101-01111, 10100-10111, 11110, 11111) SHALL produce C=0, vout=0, cout=0.
REQ-021 vout SHALL NOT depend on coe.

Reset
REQ-022 rst_n=0 SHALL immediately and asynchronously force C=16'h0000, vout=0, cout=0, independent of clk.
REQ-023 While rst_n=0 outputs SHALL hold zero; first update SHALL occur on the first rising clk edge after rst_n returns to 1.
REQ-024 Reset asserted mid-stream SHALL discard the in-flight result; no output of the pre-reset operation appears afterwards.

Verification
REQ-025 add, A=A00A, B=1004, coe=0 -> next cycle C=B00E, vout=0, cout=0.
REQ-026 add, A=8012, B=8002, coe=0 -> C=0014, vout=1, cout=1; same with coe=1 -> C=0014, vout=1, cout=0.
REQ-027 sub, A=8012, B=8002, coe=0 -> C=0010, vout=0, cout=1; subu A=1004, B=A00A -> C=6FFA, vout=1, cout=0.
REQ-028 A=F14A, B=F002: sll -> C528; srl -> 3C52; sra -> FC52; sla -> C528; all vout=0, cout=0.
REQ-029 A=F14A, B=F002 (signed -3766 vs -4094): sgt/sge/sne -> 0001; slt/sle/seq -> 0000; not -> 0EB5; and -> F002; xor -> 0148.
REQ-030 Drive add, A=FFFF, B=0001, then assert rst_n=0 between clk edges -> outputs go to 0 without a clock edge; after release, next edge yields C=0000, cout=1, vout=0.
